// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types, arctangent table and gain constant for the iterative CORDIC engine
package cordic_pkg;
  typedef enum logic {CORDIC_ROT, CORDIC_VEC} cordic_mode_t;
  typedef enum logic [1:0] {IDLE, PREROT, ITER, DONE} state_t;
  localparam int ITERS_MAX = 32;
  // 1/An in Q30
  localparam logic [31:0] K_INV_Q30 = 32'd652032874;
  // atan(2**-i) in 32-bit BAM (2**31 = pi)
  localparam logic [31:0] ATAN_TABLE [ITERS_MAX] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };
  function automatic longint round_shift(longint v, int s);
    return s <= 0 ? v : (v + (longint'(1) << (s - 1))) >>> s;
  endfunction
endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: rounded arctangent of 2**-idx in WIDTH-bit BAM
// idx  : micro-rotation index 0..31
// atan : round(atan(2**-idx)/pi * 2**(WIDTH-1))
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [4:0]       idx,
  output logic [WIDTH-1:0] atan
);
  always_comb atan = WIDTH'(round_shift(longint'(ATAN_TABLE[idx]), 32 - WIDTH));
endmodule

// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine: iterative CORDIC, rotation (cos/sin) and vectoring (atan2/magnitude) per transaction
// clock/reset (sync, active-low); in_valid/in_ready/in_mode/in_x/in_y/in_z request side;
// out_valid/out_ready/out_mode/out_x/out_y/out_z result side (x,y WIDTH+2 bits, z BAM WIDTH bits)
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITERS = 14
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [WIDTH-1:0]        in_x,
  input  logic [WIDTH-1:0]        in_y,
  input  logic [WIDTH-1:0]        in_z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_mode,
  output logic signed [WIDTH+1:0] out_x,
  output logic signed [WIDTH+1:0] out_y,
  output logic [WIDTH-1:0]        out_z
);
  localparam int DW = WIDTH + 2;
  localparam logic signed [DW-1:0] K0 = DW'(round_shift(longint'(K_INV_Q30), 32 - WIDTH));
  state_t state, next;
  cordic_mode_t mode;
  logic [WIDTH-1:0] op_x, op_y, op_z, z, pz, nz, atan;
  logic signed [DW-1:0] x, y, ex, ey, px, py, nx, ny, xs, ys;
  logic [4:0] i;
  logic zero, flip, d_pos;
  cordic_atan_rom #(.WIDTH(WIDTH)) u_rom (.idx(i), .atan(atan));
  assign in_ready = state == IDLE;
  always_comb begin
    ex = {{2{op_x[WIDTH-1]}}, op_x};
    ey = {{2{op_y[WIDTH-1]}}, op_y};
    // angles beyond +/-pi/2 start from the vector (-K,0), i.e. pre-rotated by pi
    flip = op_z[WIDTH-1] ^ op_z[WIDTH-2];
    px = mode == CORDIC_ROT ? (flip ? -K0 : K0) : (op_x[WIDTH-1] ? -ex : ex);
    py = mode == CORDIC_ROT ? '0 : (op_x[WIDTH-1] ? -ey : ey);
    pz = mode == CORDIC_ROT ? {op_z[WIDTH-1] ^ flip, op_z[WIDTH-2:0]}
                            : {op_x[WIDTH-1], {(WIDTH-1){1'b0}}};
    d_pos = mode == CORDIC_ROT ? !z[WIDTH-1] : y[DW-1];
    xs = x >>> i;
    ys = y >>> i;
    nx = d_pos ? x - ys : x + ys;
    ny = d_pos ? y + xs : y - xs;
    nz = d_pos ? z - atan : z + atan;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:   next = in_valid ? PREROT : IDLE;
      PREROT: next = ITER;
      ITER:   next = i == 5'(ITERS - 1) ? DONE : ITER;
      DONE:   next = out_valid && out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      i <= '0;
      out_valid <= 1'b0;
      out_mode <= 1'b0;
      out_x <= '0;
      out_y <= '0;
      out_z <= '0;
    end else begin
      state <= next;
      if (in_valid && in_ready) begin
        mode <= cordic_mode_t'(in_mode);
        op_x <= in_x;
        op_y <= in_y;
        op_z <= in_z;
        zero <= in_mode && in_x == '0 && in_y == '0;
      end
      if (state == PREROT) begin
        x <= px;
        y <= py;
        z <= pz;
        i <= '0;
      end
      if (state == ITER) begin
        x <= nx;
        y <= ny;
        z <= nz;
        i <= i + 5'd1;
      end
      // result register stage: out_valid follows the last micro-rotation by one cycle
      if (state == DONE && !out_valid) begin
        out_valid <= 1'b1;
        out_mode <= mode;
        out_x <= zero ? '0 : x;
        out_y <= zero ? '0 : y;
        out_z <= zero ? '0 : z;
      end
      if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cordic_iter_engine.sv
// tb_cordic_iter_engine: randomized and directed checks of cordic_iter_engine against a real-arithmetic model
module tb_cordic_iter_engine;
  localparam real PI = 3.14159265358979323846;
  localparam int ITERS = 14;
  localparam int LAT = ITERS + 2;
  localparam int TOL_ROT = 6;
  localparam int TOL_ANG = 5;
  localparam int TOL_MAG = 10;
  logic clock = 1'b0, reset = 1'b0, in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic [15:0] in_x = '0, in_y = '0, in_z = '0;
  logic in_ready, out_valid, out_mode;
  logic signed [17:0] out_x, out_y;
  logic [15:0] out_z;
  int n_checks = 0, n_fail = 0;
  cordic_iter_engine #(.WIDTH(16), .ITERS(ITERS)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_x(out_x), .out_y(out_y), .out_z(out_z)
  );
  always #5 clock = ~clock;
  function automatic int rot_cos(int z);
    return int'(16384.0 * $cos(real'(z) * PI / 32768.0));
  endfunction
  function automatic int rot_sin(int z);
    return int'(16384.0 * $sin(real'(z) * PI / 32768.0));
  endfunction
  function automatic int vec_ang(int x, int y);
    return (x == 0 && y == 0) ? 0 : int'($atan2(real'(y), real'(x)) / PI * 32768.0);
  endfunction
  function automatic int vec_mag(int x, int y);
    real an = 1.0;
    for (int k = 0; k < ITERS; k++) an = an * $sqrt(1.0 + 2.0 ** (-2.0 * k));
    return int'(an * $sqrt(real'(x) * x + real'(y) * y));
  endfunction
  function automatic bit near(int a, int b, int tol);
    return (a - b) <= tol && (b - a) <= tol;
  endfunction
  function automatic bit near_ang(logic [15:0] a, int b, int tol);
    int d = int'(shortint'(int'(a) - b));
    return d <= tol && -d <= tol;
  endfunction
  task automatic run_op(input logic m, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z, output int lat);
    @(negedge clock);
    in_mode = m; in_x = x; in_y = y; in_z = z; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask
  task automatic drain;
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_mode !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b out_mode=%b, want 1 0 0", in_ready, out_valid, out_mode);
    end
    n_checks++;
    if (out_x !== 0 || out_y !== 0 || out_z !== 0) begin
      n_fail++;
      $display("FAIL reset_data: x=%0d y=%0d z=%0d, want 0 0 0", out_x, out_y, out_z);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask
  task automatic test_rotation;
    int zs[3] = '{0, 16384, -32768};
    int ec[3] = '{16384, 0, -16384};
    int es[3] = '{0, 16384, 0};
    int lat;
    for (int k = 0; k < 3; k++) begin
      run_op(1'b0, 16'(zs[k]), 16'h1234, 16'(zs[k]), lat);
      n_checks++;
      if (lat !== LAT || out_mode !== 1'b0) begin
        n_fail++;
        $display("FAIL rot_latency z=%0d: lat=%0d mode=%b, want %0d 0", zs[k], lat, out_mode, LAT);
      end
      n_checks++;
      if (!near(out_x, ec[k], TOL_ROT) || !near(out_y, es[k], TOL_ROT)) begin
        n_fail++;
        $display("FAIL rot_dir z=%0d: cos=%0d sin=%0d, want %0d %0d", zs[k], out_x, out_y, ec[k], es[k]);
      end
      drain();
    end
  endtask
  task automatic test_vectoring;
    int xs[4] = '{16384, -16384, -32768, 0};
    int ys[4] = '{16384, 0, 0, 0};
    int lat;
    for (int k = 0; k < 4; k++) begin
      run_op(1'b1, 16'(xs[k]), 16'(ys[k]), 16'h5555, lat);
      n_checks++;
      if (lat !== LAT || out_mode !== 1'b1) begin
        n_fail++;
        $display("FAIL vec_latency x=%0d y=%0d: lat=%0d mode=%b, want %0d 1", xs[k], ys[k], lat, out_mode, LAT);
      end
      if (xs[k] == 0 && ys[k] == 0) begin
        n_checks++;
        if (out_x !== 0 || out_y !== 0 || out_z !== 0) begin
          n_fail++;
          $display("FAIL vec_zero: x=%0d y=%0d z=%0d, want 0 0 0", out_x, out_y, out_z);
        end
      end else begin
        n_checks++;
        if (!near_ang(out_z, vec_ang(xs[k], ys[k]), TOL_ANG) || !near(out_x, vec_mag(xs[k], ys[k]), TOL_MAG)) begin
          n_fail++;
          $display("FAIL vec_dir x=%0d y=%0d: ang=%0d mag=%0d, want %0d %0d", xs[k], ys[k],
                   $signed(out_z), out_x, vec_ang(xs[k], ys[k]), vec_mag(xs[k], ys[k]));
        end
      end
      drain();
    end
  endtask
  task automatic test_random;
    int lat, x, y, z;
    logic m;
    for (int k = 0; k < 40; k++) begin
      m = 1'($urandom);
      z = int'(shortint'($urandom));
      do begin
        x = int'(shortint'($urandom));
        y = int'(shortint'($urandom));
      end while (x * x + y * y < 8192 * 8192);
      run_op(m, 16'(x), 16'(y), 16'(z), lat);
      n_checks++;
      if (lat !== LAT || out_mode !== m) begin
        n_fail++;
        $display("FAIL rand_latency #%0d: lat=%0d mode=%b, want %0d %b", k, lat, out_mode, LAT, m);
      end
      n_checks++;
      if (m == 1'b0 && (!near(out_x, rot_cos(z), TOL_ROT) || !near(out_y, rot_sin(z), TOL_ROT))) begin
        n_fail++;
        $display("FAIL rand_rot z=%0d: cos=%0d sin=%0d, want %0d %0d", z, out_x, out_y, rot_cos(z), rot_sin(z));
      end else if (m == 1'b1 && (!near_ang(out_z, vec_ang(x, y), TOL_ANG) || !near(out_x, vec_mag(x, y), TOL_MAG))) begin
        n_fail++;
        $display("FAIL rand_vec x=%0d y=%0d: ang=%0d mag=%0d, want %0d %0d", x, y, $signed(out_z), out_x,
                 vec_ang(x, y), vec_mag(x, y));
      end
      drain();
    end
  endtask
  task automatic test_backpressure;
    int lat, seen;
    logic [17:0] hx, hy;
    logic [15:0] hz;
    out_ready = 1'b0;
    run_op(1'b0, 16'h0, 16'h0, 16'd5461, lat);
    hx = out_x; hy = out_y; hz = out_z;
    n_checks++;
    if (lat !== LAT || !near(out_x, rot_cos(5461), TOL_ROT) || !near(out_y, rot_sin(5461), TOL_ROT)) begin
      n_fail++;
      $display("FAIL bp_result: lat=%0d cos=%0d sin=%0d, want %0d %0d %0d", lat, out_x, out_y, LAT,
               rot_cos(5461), rot_sin(5461));
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      in_valid = c[0];
      in_mode = 1'b1;
      in_x = 16'($urandom);
      in_y = 16'($urandom);
      @(posedge clock);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_x !== hx || out_y !== hy || out_z !== hz) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: valid=%b ready=%b x=%0d y=%0d z=%0d, want 1 0 %0d %0d %0d", c,
                 out_valid, in_ready, out_x, out_y, out_z, $signed(hx), $signed(hy), hz);
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
    seen = 0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL bp_ignored: %0d spurious result cycles, want 0", seen);
    end
  endtask
  task automatic test_reset_mid;
    int lat;
    @(negedge clock);
    in_mode = 1'b0; in_z = 16'd8000; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_x !== 0 || out_y !== 0 || out_z !== 0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b ready=%b x=%0d y=%0d z=%0d, want 0 1 0 0 0", out_valid, in_ready,
               out_x, out_y, out_z);
    end
    @(negedge clock);
    reset = 1'b1;
    run_op(1'b0, 16'h0, 16'h0, 16'hE000, lat);
    n_checks++;
    if (lat !== LAT || !near(out_x, rot_cos(-8192), TOL_ROT) || !near(out_y, rot_sin(-8192), TOL_ROT)) begin
      n_fail++;
      $display("FAIL reset_fresh: lat=%0d cos=%0d sin=%0d, want %0d %0d %0d", lat, out_x, out_y, LAT,
               rot_cos(-8192), rot_sin(-8192));
    end
    drain();
  endtask
  initial begin
    test_reset();
    test_rotation();
    test_vectoring();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
